div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 167 ++++++++++++++++
 tb/tb_div_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared iterative divider.
// Handles divide-by-zero locally and aborts the divider after TIMEOUT wait cycles.
module div_arbiter #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] x1,
  input  logic [31:0] y1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] resp_q,
  output logic [32:0] resp_r,
  output logic        resp_err,
  output logic        div_start,
  output logic        div_abort,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [32:0] div_r
);

  localparam int unsigned    CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [31:0]     resp_quot_q, resp_quot_d;
  logic [32:0]     resp_rem_q, resp_rem_d;
  logic            resp_err_q, resp_err_d;
  logic            div_start_q, div_start_d;
  logic            div_abort_q, div_abort_d;
  logic [31:0]     div_x_q, div_x_d;
  logic [31:0]     div_y_q, div_y_d;

  logic        win;
  logic [31:0] win_x;
  logic [31:0] win_y;

  // With both requesting, the one not served last goes next.
  assign win   = (req0 && req1) ? ~last_q : req1;
  assign win_x = win ? x1 : x0;
  assign win_y = win ? y1 : y0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    resp_quot_d = resp_quot_q;
    resp_rem_d  = resp_rem_q;
    resp_err_d  = resp_err_q;
    div_x_d     = div_x_q;
    div_y_d     = div_y_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    div_start_d = 1'b0;
    div_abort_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d = win;
          last_d  = win;
          div_x_d = win_x;
          div_y_d = win_y;
          if (win_y == 32'd0) begin
            resp_quot_d = 32'hFFFF_FFFF;
            resp_rem_d  = {1'b0, win_x};
            resp_err_d  = 1'b1;
            ack0_d      = ~win;
            ack1_d      = win;
            state_d     = StResp;
          end else begin
            div_start_d = 1'b1;
            state_d     = StLaunch;
          end
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A completion in the final allowed cycle beats the timeout.
        if (div_done) begin
          resp_quot_d = div_q;
          resp_rem_d  = div_r;
          resp_err_d  = 1'b0;
          ack0_d      = ~grant_q;
          ack1_d      = grant_q;
          state_d     = StResp;
        end else if (cnt_q == CntMax) begin
          div_abort_d = 1'b1;
          resp_quot_d = '0;
          resp_rem_d  = '0;
          resp_err_d  = 1'b1;
          ack0_d      = ~grant_q;
          ack1_d      = grant_q;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      resp_quot_q <= '0;
      resp_rem_q  <= '0;
      resp_err_q  <= 1'b0;
      div_start_q <= 1'b0;
      div_abort_q <= 1'b0;
      div_x_q     <= '0;
      div_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      resp_quot_q <= resp_quot_d;
      resp_rem_q  <= resp_rem_d;
      resp_err_q  <= resp_err_d;
      div_start_q <= div_start_d;
      div_abort_q <= div_abort_d;
      div_x_q     <= div_x_d;
      div_y_q     <= div_y_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign resp_q    = resp_quot_q;
  assign resp_r    = resp_rem_q;
  assign resp_err  = resp_err_q;
  assign div_start = div_start_q;
  assign div_abort = div_abort_q;
  assign div_x     = div_x_q;
  assign div_y     = div_y_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider responder plus a transaction-level
// reference model predicting winner, result, latency and pulse counts.
module tb_div_arbiter;

  localparam int unsigned Timeout = 40;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic        ack0, ack1;
  logic [31:0] resp_q;
  logic [32:0] resp_r;
  logic        resp_err;
  logic        div_start, div_abort;
  logic [31:0] div_x, div_y;
  logic        div_done = 1'b0;
  logic [31:0] div_q = '0;
  logic [32:0] div_r = '0;

  int n_pass = 0, n_total = 0;
  int n_start = 0, n_abort = 0, n_ack = 0;
  int dly = 1;   // divider response delay after div_start; 0 = never responds
  bit spur = 1'b0;
  int last = 1;  // model of the last-served requester
  int pend = 0;
  logic [31:0] x_l = '0, y_l = '0;
  logic [31:0] prev_q = '0;
  logic [32:0] prev_r = '0;
  logic        prev_err = 1'b0;

  div_arbiter #(.TIMEOUT(Timeout)) dut (
    .clk(clk), .rst_b(rst_b), .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .ack0(ack0), .ack1(ack1), .resp_q(resp_q), .resp_r(resp_r), .resp_err(resp_err),
    .div_start(div_start), .div_abort(div_abort), .div_x(div_x), .div_y(div_y),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div_start) n_start <= n_start + 1;
    if (div_abort) n_abort <= n_abort + 1;
    if (ack0 || ack1) n_ack <= n_ack + 1;
  end

  // Divider model: done is raised in the cycle that lies dly cycles after div_start.
  always @(negedge clk) begin
    div_done = 1'b0;
    if (!rst_b) pend = 0;
    if (spur) begin
      div_done = 1'b1;
      div_q    = 32'hDEAD_BEEF;
      div_r    = '1;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        div_done = 1'b1;
        div_q    = (y_l == 0) ? 32'd0 : x_l / y_l;
        div_r    = {1'b0, (y_l == 0) ? 32'd0 : x_l % y_l};
      end
    end
    if (div_start && rst_b && dly > 0) begin
      pend = dly;
      x_l  = div_x;
      y_l  = div_y;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // mode: 0 drop winner's req after ack, 1 keep all reqs, 2 drop all reqs
  task automatic run_txn(input string tag, input bit r0, input bit r1, input int mode,
                         input bit early);
    int          win, lat, st0, ab0, elat, est, eab;
    logic [31:0] ex, ey, eq;
    logic [32:0] er;
    logic        ee;
    bit          seen;
    win = (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
    ex  = win ? x1 : x0;
    ey  = win ? y1 : y0;
    if (ey == 0) begin
      eq = 32'hFFFF_FFFF; er = {1'b0, ex}; ee = 1'b1; elat = 2; est = 0; eab = 0;
    end else if (dly >= 1 && dly <= int'(Timeout)) begin
      eq = ex / ey; er = {1'b0, ex % ey}; ee = 1'b0; elat = 3 + dly; est = 1; eab = 0;
    end else begin
      eq = '0; er = '0; ee = 1'b1; elat = 3 + int'(Timeout); est = 1; eab = 1;
    end
    last = win;
    st0  = n_start;
    ab0  = n_abort;
    req0 = r0;
    req1 = r1;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (early && i == 0) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (ack0 || ack1) seen = 1'b1;
    end
    check({tag, " ack_seen"}, 64'(seen), 64'(1));
    check({tag, " ack_who"}, 64'({ack1, ack0}), 64'(win ? 2'b10 : 2'b01));
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " resp_q"}, 64'(resp_q), 64'(eq));
    check({tag, " resp_r"}, 64'(resp_r), 64'(er));
    check({tag, " resp_err"}, 64'(resp_err), 64'(ee));
    check({tag, " abort_at_ack"}, 64'(div_abort), 64'(eab));
    check({tag, " div_xy"}, {div_x, div_y}, {ex, ey});
    if (mode == 2) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end else if (mode == 0) begin
      if (win == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end
    @(negedge clk);
    check({tag, " ack_one_cycle"}, 64'({ack1, ack0}), 64'(0));
    check({tag, " resp_hold"}, {resp_q, 31'd0, resp_err, 32'd0}, {eq, 31'd0, ee, 32'd0});
    check({tag, " start_cnt"}, 64'(n_start - st0), 64'(est));
    check({tag, " abort_cnt"}, 64'(n_abort - ab0), 64'(eab));
    prev_q   = eq;
    prev_r   = er;
    prev_err = ee;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, s0, pat;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({ack1, ack0, div_start, div_abort, resp_err}), 64'(0));
    check("rst_resp_q", 64'(resp_q), 64'(0));
    check("rst_resp_r", 64'(resp_r), 64'(0));
    check("rst_div_xy", {div_x, div_y}, 64'(0));
    rst_b = 1'b1;
    a0 = n_abort;
    repeat (4) @(negedge clk);
    check("no_abort_after_rst", 64'(n_abort - a0), 64'(0));

    // Simultaneous requests: 0 first, then 1; then held continuously -> 0,1,0,1
    x0 = 32'd1000; y0 = 32'd7; x1 = 32'd999; y1 = 32'd10; dly = 5;
    run_txn("simul_first", 1'b1, 1'b1, 0, 1'b0);
    run_txn("simul_second", 1'b0, 1'b1, 0, 1'b0);
    run_txn("alt0", 1'b1, 1'b1, 1, 1'b0);
    run_txn("alt1", 1'b1, 1'b1, 1, 1'b0);
    run_txn("alt2", 1'b1, 1'b1, 1, 1'b0);
    run_txn("alt3", 1'b1, 1'b1, 2, 1'b0);

    // Single requester, D=35: quotient 27, remainder 158, ack in cycle 38
    x0 = 32'd4802; y0 = 32'd172; dly = 35;
    run_txn("single", 1'b1, 1'b0, 0, 1'b0);

    // Divide by zero
    x1 = 32'd100; y1 = 32'd0;
    run_txn("div0", 1'b0, 1'b1, 0, 1'b0);

    // Divider never answers -> abort
    x0 = 32'd77; y0 = 32'd3; dly = 0;
    run_txn("timeout", 1'b1, 1'b0, 0, 1'b0);

    // Completion in the last allowed wait cycle wins over the timeout
    x1 = 32'hFFFF_FFFF; y1 = 32'd16; dly = int'(Timeout);
    run_txn("done_at_timeout", 1'b0, 1'b1, 0, 1'b0);

    // Req falls right after grant: operation still completes
    x0 = 32'd123456; y0 = 32'd321; dly = 3;
    run_txn("early_drop", 1'b1, 1'b0, 0, 1'b1);

    // div_done outside WAIT is ignored
    a0 = n_ack;
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("spur_no_ack", 64'(n_ack - a0), 64'(0));
    check("spur_resp_hold", {resp_q, 31'd0, resp_err}, {prev_q, 31'd0, prev_err});
    check("spur_resp_r_hold", 64'(resp_r), 64'(prev_r));
    x1 = 32'd50; y1 = 32'd6; dly = 2;
    run_txn("after_spur", 1'b0, 1'b1, 0, 1'b0);

    // Reset during WAIT abandons the operation
    x0 = 32'd900; y0 = 32'd9; dly = 0;
    a0 = n_ack;
    req0 = 1'b1;
    repeat (6) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("rstwait_ctrl", 64'({ack1, ack0, div_start, div_abort, resp_err}), 64'(0));
    check("rstwait_resp", {resp_q, resp_r[31:0]}, 64'(0));
    check("rstwait_div_xy", {div_x, div_y}, 64'(0));
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    last = 1;
    a0 = n_abort;
    s0 = n_ack;
    repeat (Timeout + 5) @(negedge clk);
    check("rstwait_no_abort", 64'(n_abort - a0), 64'(0));
    check("rstwait_no_ack", 64'(n_ack - s0), 64'(0));
    x1 = 32'd81; y1 = 32'd9; dly = 4;
    run_txn("after_rst_rr", 1'b1, 1'b1, 2, 1'b0);

    // Randomized transactions against the model
    for (int i = 0; i < 14; i++) begin
      pat = int'($urandom_range(1, 3));
      x0  = $urandom;
      x1  = $urandom;
      y0  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      y1  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      dly = int'($urandom_range(0, Timeout + 1));
      run_txn($sformatf("rand%0d", i), pat[0], pat[1], 2, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
